moving_avg_arbiter: RTL and testbench

//   Round-robin arbiter/sequencer sharing one moving-average custom-instruction engine
//   (start/done, clk_en-gated, multi-cycle) between N sample requesters (audio channels).

---
 rtl/moving_avg_arbiter.sv | 126 ++++++++++++
 tb/tb_moving_avg_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/moving_avg_arbiter.sv
// Round-robin sequencer sharing one start/done moving-average engine between N_REQ requesters.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP, with a watchdog on WAIT.
module moving_avg_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      resp_valid,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    output logic                  busy,
    output logic                  eng_clk_en,
    output logic                  eng_start,
    output logic [31:0]           eng_dataa,
    output logic [31:0]           eng_datab,
    input  logic [31:0]           eng_result,
    input  logic                  eng_done,
    output logic [1:0]            state_dbg
);

    // Handshake: req[i] is a level held (with req_data stable) until resp_valid[i]
    // pulses for one cycle; resp_data/resp_err are valid in that cycle and held after.
    localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state, state_nx;
    logic [SEL_W-1:0]   rr;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   pick;
    logic [SEL_W-1:0]   idx;
    logic               pick_vld;
    logic [CNT_W-1:0]   wdog;
    logic               timeout_hit;

    assign timeout_hit = (wdog == CNT_W'(TIMEOUT - 1));
    assign state_dbg   = state;

    // Scan offsets high to low so the nearest set bit after rr wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = SEL_W'((int'(rr) + i) % N_REQ);
            if (req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_vld) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (eng_done || timeout_hit) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        eng_start  = (state == ISSUE);
        eng_clk_en = (state == ISSUE) || (state == WAIT);
        resp_valid = (state == RESP) ? grant : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr        <= SEL_W'(N_REQ - 1);
            sel       <= '0;
            grant     <= '0;
            wdog      <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
            eng_dataa <= '0;
            eng_datab <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant     <= N_REQ'(1) << pick;
                        sel       <= pick;
                        eng_dataa <= req_data[32*int'(pick) +: 32];
                        eng_datab <= 32'(pick);
                    end
                end
                ISSUE: wdog <= '0;
                WAIT: begin
                    wdog <= wdog + 1'b1;
                    // A done arriving on the last watchdog cycle still counts as success.
                    if (eng_done) begin
                        resp_data <= eng_result;
                        resp_err  <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    rr        <= sel;
                    grant     <= '0;
                    eng_dataa <= '0;
                    eng_datab <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_moving_avg_arbiter.sv
// Scoreboard bench for moving_avg_arbiter with a behavioural start/done engine model.
module tb_moving_avg_arbiter;
  localparam int N   = 4;
  localparam int TO  = 15;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    grant, resp_valid;
  logic [31:0]     resp_data, eng_dataa, eng_datab;
  logic            resp_err, busy, eng_clk_en, eng_start;
  logic [31:0]     eng_result = 32'hdead_beef;
  logic            eng_done;
  logic [1:0]      state_dbg;

  logic [31:0]     chan_data [N];
  logic [35:0]     exp_q [$];
  int              n_checks = 0;
  int              n_fail = 0;
  int              cyc = 0;
  int              start_cyc = 0;
  int              last_lat = 0;

  logic            never_done = 1'b0;
  logic            spurious = 1'b0;
  logic            model_done = 1'b0;
  logic            run = 1'b0;
  int              ecnt = 0;
  logic [31:0]     lat_data = '0;

  assign eng_done = model_done | spurious;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_data[32*g +: 32] = chan_data[g];
  end

  moving_avg_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy), .eng_clk_en(eng_clk_en), .eng_start(eng_start),
    .eng_dataa(eng_dataa), .eng_datab(eng_datab),
    .eng_result(eng_result), .eng_done(eng_done), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_res(input logic [31:0] d);
    return {16'h0, d[15:0] >> 4};
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic push(input int ch, input bit err);
    exp_q.push_back({3'(ch), err, err ? 32'h0 : exp_res(chan_data[ch])});
  endtask

  task automatic pop_check;
    logic [35:0] e;
    if (exp_q.size() == 0) begin
      check("resp_unexpected", 64'(resp_valid), 64'h0);
    end else begin
      e = exp_q.pop_front();
      check("resp_valid", 64'(resp_valid), 64'(N'(1) << e[35:33]));
      check("resp_data", 64'(resp_data), 64'(e[31:0]));
      check("resp_err", 64'(resp_err), 64'(e[32]));
      last_lat = cyc - start_cyc;
    end
  endtask

  task automatic serve(input int n, input bit drop, input bit chk_gap);
    int got = 0;
    int guard = 0;
    int prev = -1;
    while (got < n && guard < 400) begin
      tick;
      guard++;
      if (|resp_valid) begin
        pop_check();
        if (chk_gap && prev >= 0) check("b2b_gap", 64'(cyc - prev), 64'd6);
        prev = cyc;
        if (drop) req = req & ~resp_valid;
        got++;
      end
    end
    if (got < n) check("serve_timeout", 64'(got), 64'(n));
  endtask

  task automatic do_reset;
    tick;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // engine model: done LAT cycles after the start cycle; checks clk_en stays up mid-op
  always @(negedge clk) begin
    logic [35:0] e;
    model_done = 1'b0;
    if (reset) begin
      run  = 1'b0;
      ecnt = 0;
    end else if (eng_start) begin
      run       = 1'b1;
      ecnt      = 0;
      lat_data  = eng_dataa;
      start_cyc = cyc;
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        check("issue_grant", 64'(grant), 64'(N'(1) << e[35:33]));
        check("issue_dataa", 64'(eng_dataa), 64'(chan_data[e[35:33]]));
        check("issue_datab", 64'(eng_datab), 64'(e[35:33]));
      end
    end else if (run) begin
      check("clk_en_hold", 64'(eng_clk_en | (|resp_valid)), 64'd1);
      if (!eng_clk_en) begin
        run = 1'b0;
      end else begin
        ecnt++;
        if (ecnt == LAT && !never_done) begin
          model_done = 1'b1;
          run = 1'b0;
        end
      end
    end
    eng_result = model_done ? exp_res(lat_data) : 32'hdead_beef;
  end

  initial begin
    for (int i = 0; i < N; i++) chan_data[i] = '0;

    // reset state
    tick;
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_resp_valid", 64'(resp_valid), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_clk_en", 64'(eng_clk_en), 64'h0);
    check("rst_start", 64'(eng_start), 64'h0);
    check("rst_resp_data", 64'(resp_data), 64'h0);
    check("rst_resp_err", 64'(resp_err), 64'h0);
    check("rst_dataa", 64'(eng_dataa), 64'h0);
    check("rst_datab", 64'(eng_datab), 64'h0);
    tick;
    reset = 1'b0;

    // single request on channel 0, cycle-by-cycle
    tick;
    chan_data[0] = 32'h10;
    req = 4'b0001;
    push(0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick;
      check($sformatf("single_grant_c%0d", k), 64'(grant), 64'h1);
      check($sformatf("single_start_c%0d", k), 64'(eng_start), 64'(k == 1));
      check($sformatf("single_clken_c%0d", k), 64'(eng_clk_en), 64'(k < 5));
      if (k < 5) check($sformatf("single_nresp_c%0d", k), 64'(resp_valid), 64'h0);
      if (k == 5) begin
        pop_check();
        req = '0;
      end
    end
    check("single_lat", 64'(last_lat), 64'd4);
    check("single_data_val", 64'(resp_data), 64'h1);
    tick;
    check("single_idle_busy", 64'(busy), 64'h0);
    check("single_idle_grant", 64'(grant), 64'h0);

    // all four held from a fresh reset: 0,1,2,3,0,1,2,3 at one per 6 cycles
    do_reset();
    for (int i = 0; i < N; i++) chan_data[i] = $urandom;
    req = 4'b1111;
    for (int t = 0; t < 8; t++) push(t % N, 1'b0);
    serve(8, 1'b0, 1'b1);
    req = '0;

    // serve 2 alone, then 0101 must wrap to 0 before 2
    tick;
    chan_data[2] = $urandom_range(0, 32'hffff);
    req = 4'b0100;
    push(2, 1'b0);
    serve(1, 1'b1, 1'b0);
    chan_data[0] = $urandom_range(0, 32'hffff);
    chan_data[2] = $urandom_range(0, 32'hffff);
    req = 4'b0101;
    push(0, 1'b0);
    push(2, 1'b0);
    serve(2, 1'b1, 1'b0);

    // engine never completes: watchdog abort, then a normal request
    tick;
    never_done = 1'b1;
    chan_data[1] = $urandom;
    req = 4'b0010;
    push(1, 1'b1);
    serve(1, 1'b1, 1'b0);
    check("wdog_lat", 64'(last_lat), 64'(TO + 1));
    never_done = 1'b0;
    chan_data[3] = $urandom;
    req = 4'b1000;
    push(3, 1'b0);
    serve(1, 1'b1, 1'b0);
    check("after_wdog_lat", 64'(last_lat), 64'd4);

    // reset while in WAIT: leave rr at 0 first, then abort a transaction on channel 2
    chan_data[0] = $urandom;
    req = 4'b0001;
    push(0, 1'b0);
    serve(1, 1'b1, 1'b0);
    tick;
    chan_data[2] = $urandom;
    req = 4'b0100;
    tick;
    tick;
    tick;
    check("pre_rst_wait", 64'(state_dbg), 64'd2);
    #2 reset = 1'b1;
    #1;
    check("midrst_grant", 64'(grant), 64'h0);
    check("midrst_resp_valid", 64'(resp_valid), 64'h0);
    check("midrst_busy", 64'(busy), 64'h0);
    check("midrst_clk_en", 64'(eng_clk_en), 64'h0);
    check("midrst_start", 64'(eng_start), 64'h0);
    check("midrst_dataa", 64'(eng_dataa), 64'h0);
    check("midrst_resp_data", 64'(resp_data), 64'h0);
    tick;
    req = '0;
    tick;
    check("midrst_hold_resp", 64'(resp_valid), 64'h0);
    reset = 1'b0;
    chan_data[0] = $urandom;
    chan_data[1] = $urandom;
    req = 4'b0011;
    push(0, 1'b0);
    push(1, 1'b0);
    serve(2, 1'b1, 1'b0);

    // spurious done while idle is ignored
    tick;
    spurious = 1'b1;
    tick;
    spurious = 1'b0;
    check("spur_busy", 64'(busy), 64'h0);
    check("spur_resp_valid", 64'(resp_valid), 64'h0);
    check("spur_resp_data", 64'(resp_data), 64'(exp_res(chan_data[1])));
    tick;
    check("spur_busy2", 64'(busy), 64'h0);
    check("sb_empty", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
